cam_alloc: RTL and testbench

Multi-port ternary CAM with per-entry valid bits and automatic free-slot allocation. It is the successor to the fixed-address masked CAM and is used for tag and rename lookups. Writers do not supply an address: the block allocates free entries, stores a per-entry don't-care mask, supports explicit invalidation and full flush, and reports occupancy. Search results are optionally registered.

---
 rtl/cam_alloc.sv | 173 +++++++++++++++++
 tb/tb_cam_alloc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_alloc.sv
// Ternary CAM with self-allocating writes, per-entry don't-care masks,
// invalidate/flush, occupancy tracking and optionally registered search results.
module cam_alloc #(
  parameter int DATA    = 16,
  parameter int DEPTH   = 32,
  parameter int WRITE   = 2,
  parameter int READ    = 2,
  parameter int INV     = 2,
  parameter int MSB     = 0,
  parameter int OUT_REG = 1,
  parameter int ADDR    = $clog2(DEPTH),
  parameter int CNT     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WRITE-1:0]      we_,
  input  logic [WRITE*DATA-1:0] wd,
  input  logic [WRITE*DATA-1:0] wcare,
  output logic [WRITE-1:0]      wack,
  output logic [WRITE*ADDR-1:0] waddr,
  input  logic [INV-1:0]        inv_,
  input  logic [INV*ADDR-1:0]   iaddr,
  input  logic                  flush_,
  input  logic [READ-1:0]       re_,
  input  logic [READ*DATA-1:0]  rm,
  input  logic [READ*DATA-1:0]  rd,
  output logic [READ-1:0]       match,
  output logic [READ-1:0]       multi,
  output logic [READ*ADDR-1:0]  raddr,
  output logic [CNT-1:0]        count,
  output logic                  full,
  output logic                  empty
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DATA-1:0]  data_q [DEPTH];
  logic [DATA-1:0]  care_q [DEPTH];
  logic [CNT-1:0]   count_q, count_d;

  logic [DEPTH-1:0] avail;
  logic [DEPTH-1:0] allocMask;
  logic [DEPTH-1:0] invMask;
  logic             found;
  logic [CNT-1:0]   nAck;
  logic [CNT-1:0]   nInv;

  // Ports claim free entries in ascending port order; each grant removes the slot from the pool.
  always_comb begin
    avail = ~valid_q;
    wack  = '0;
    waddr = '0;
    found = 1'b0;
    for (int w = 0; w < WRITE; w++) begin
      found = 1'b0;
      if (!we_[w] && flush_) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (!found && avail[e]) begin
            found                   = 1'b1;
            avail[e]                = 1'b0;
            wack[w]                 = 1'b1;
            waddr[w*ADDR +: ADDR]   = ADDR'(e);
          end
        end
      end
    end
    allocMask = ~valid_q & ~avail;
  end

  always_comb begin
    invMask = '0;
    for (int i = 0; i < INV; i++) begin
      if (!inv_[i]) invMask[iaddr[i*ADDR +: ADDR]] = 1'b1;
    end
  end

  // Only entries that are actually valid reduce the count; duplicates collapse in the mask.
  always_comb begin
    nAck = '0;
    nInv = '0;
    for (int w = 0; w < WRITE; w++) nAck = nAck + CNT'(wack[w]);
    for (int e = 0; e < DEPTH; e++) nInv = nInv + CNT'(invMask[e] & valid_q[e]);
    if (!flush_) begin
      valid_d = '0;
      count_d = '0;
    end else begin
      valid_d = (valid_q & ~invMask) | allocMask;
      count_d = count_q + nAck - nInv;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        data_q[e] <= '0;
        care_q[e] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int w = 0; w < WRITE; w++) begin
        if (wack[w]) begin
          data_q[waddr[w*ADDR +: ADDR]] <= wd[w*DATA +: DATA];
          care_q[waddr[w*ADDR +: ADDR]] <= wcare[w*DATA +: DATA];
        end
      end
    end
  end

  logic [DEPTH-1:0]     hits [READ];
  logic [READ-1:0]      match_d;
  logic [READ-1:0]      multi_d;
  logic [READ*ADDR-1:0] raddr_d;

  // A bit matches when masked by the search, masked by the entry, or equal.
  always_comb begin
    match_d = '0;
    multi_d = '0;
    raddr_d = '0;
    for (int r = 0; r < READ; r++) begin
      hits[r] = '0;
      for (int e = 0; e < DEPTH; e++) begin
        hits[r][e] = valid_q[e] & ~re_[r] &
                     (&(rm[r*DATA +: DATA] | care_q[e] | ~(data_q[e] ^ rd[r*DATA +: DATA])));
      end
      match_d[r] = |hits[r];
      multi_d[r] = |(hits[r] & (hits[r] - DEPTH'(1)));
      if (MSB != 0) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (hits[r][e]) raddr_d[r*ADDR +: ADDR] = ADDR'(e);
        end
      end else begin
        for (int e = DEPTH - 1; e >= 0; e--) begin
          if (hits[r][e]) raddr_d[r*ADDR +: ADDR] = ADDR'(e);
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [READ-1:0]      match_q;
      logic [READ-1:0]      multi_q;
      logic [READ*ADDR-1:0] raddr_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          match_q <= '0;
          multi_q <= '0;
          raddr_q <= '0;
        end else begin
          match_q <= match_d;
          multi_q <= multi_d;
          raddr_q <= raddr_d;
        end
      end

      assign match = match_q;
      assign multi = multi_q;
      assign raddr = raddr_q;
    end else begin : g_comb
      assign match = match_d;
      assign multi = multi_d;
      assign raddr = raddr_d;
    end
  endgenerate

  assign count = count_q;
  assign full  = (count_q == CNT'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: tb/tb_cam_alloc.sv
// Directed bench for cam_alloc: a registered lowest-priority instance and a
// combinational highest-priority instance share all stimulus.
module tb_cam_alloc;

  localparam int DATA  = 16;
  localparam int DEPTH = 32;
  localparam int ADDR  = 5;
  localparam int CNT   = 6;

  logic            clk;
  logic            reset;
  logic [1:0]      we_;
  logic [2*DATA-1:0] wd;
  logic [2*DATA-1:0] wcare;
  logic [1:0]      inv_;
  logic [2*ADDR-1:0] iaddr;
  logic            flush_;
  logic [1:0]      re_;
  logic [2*DATA-1:0] rm;
  logic [2*DATA-1:0] rd;

  logic [1:0]        wackReg, wackComb;
  logic [2*ADDR-1:0] waddrReg, waddrComb;
  logic [1:0]        matchReg, matchComb;
  logic [1:0]        multiReg, multiComb;
  logic [2*ADDR-1:0] raddrReg, raddrComb;
  logic [CNT-1:0]    countReg, countComb;
  logic              fullReg, fullComb;
  logic              emptyReg, emptyComb;

  int testsRun;
  int testsFailed;

  cam_alloc #(.MSB(0), .OUT_REG(1)) dutReg (
    .clk(clk), .reset(reset), .we_(we_), .wd(wd), .wcare(wcare),
    .wack(wackReg), .waddr(waddrReg), .inv_(inv_), .iaddr(iaddr),
    .flush_(flush_), .re_(re_), .rm(rm), .rd(rd),
    .match(matchReg), .multi(multiReg), .raddr(raddrReg),
    .count(countReg), .full(fullReg), .empty(emptyReg)
  );

  cam_alloc #(.MSB(1), .OUT_REG(0)) dutComb (
    .clk(clk), .reset(reset), .we_(we_), .wd(wd), .wcare(wcare),
    .wack(wackComb), .waddr(waddrComb), .inv_(inv_), .iaddr(iaddr),
    .flush_(flush_), .re_(re_), .rm(rm), .rd(rd),
    .match(matchComb), .multi(multiComb), .raddr(raddrComb),
    .count(countComb), .full(fullComb), .empty(emptyComb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled around the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleInputs();
    we_    = 2'b11;
    wd     = '0;
    wcare  = '0;
    inv_   = 2'b11;
    iaddr  = '0;
    flush_ = 1'b1;
    re_    = 2'b11;
    rm     = '0;
    rd     = '0;
  endtask

  task automatic allocOne(input logic [15:0] data, input logic [15:0] care, input int expAddr);
    we_          = 2'b10;
    wd[15:0]     = data;
    wcare[15:0]  = care;
    #1;
    checkOutput("alloc wack", wackReg, 32'd1);
    checkOutput("alloc waddr", waddrReg, expAddr);
    applyStimulus();
    we_ = 2'b11;
  endtask

  task automatic searchPort(input int p, input logic [15:0] key, input logic [15:0] mask,
                            input logic expM, input logic expMu, input int expA,
                            input logic expMC, input logic expMuC, input int expAC);
    re_[p]          = 1'b0;
    rd[p*DATA +: DATA] = key;
    rm[p*DATA +: DATA] = mask;
    #1;
    checkOutput("comb match", matchComb[p], expMC);
    checkOutput("comb multi", multiComb[p], expMuC);
    checkOutput("comb raddr", raddrComb[p*ADDR +: ADDR], expAC);
    applyStimulus();
    re_ = 2'b11;
    checkOutput("reg match", matchReg[p], expM);
    checkOutput("reg multi", multiReg[p], expMu);
    checkOutput("reg raddr", raddrReg[p*ADDR +: ADDR], expA);
  endtask

  initial begin
    logic [2*ADDR-1:0] pairAddr;
    testsRun    = 0;
    testsFailed = 0;
    idleInputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset count", countReg, 0);
    checkOutput("reset empty", emptyReg, 1);
    checkOutput("reset full", fullReg, 0);
    checkOutput("reset match", matchReg, 0);
    reset = 1'b1;
    applyStimulus();

    we_   = 2'b00;
    wd    = {16'h2222, 16'h1111};
    wcare = '0;
    #1;
    checkOutput("pair wack", wackReg, 32'd3);
    checkOutput("pair waddr", waddrReg, 32'h20);
    applyStimulus();
    idleInputs();
    checkOutput("count after pair", countReg, 2);
    checkOutput("empty after pair", emptyReg, 0);

    allocOne(16'h5A5A, 16'h0000, 2);
    allocOne(16'hAB00, 16'h00FF, 3);
    allocOne(16'h0C04, 16'h0000, 4);
    allocOne(16'h0C05, 16'h0000, 5);
    allocOne(16'h0C06, 16'h0000, 6);
    allocOne(16'h5A5A, 16'h0000, 7);
    checkOutput("count eight", countReg, 8);

    searchPort(0, 16'hABCD, 16'h0000, 1, 0, 3, 1, 0, 3);
    searchPort(0, 16'hAC00, 16'h0000, 0, 0, 0, 0, 0, 0);
    searchPort(1, 16'h5A5A, 16'h0000, 1, 1, 2, 1, 1, 7);
    searchPort(1, 16'h0000, 16'hFFFF, 1, 1, 0, 1, 1, 7);
    searchPort(0, 16'h0C00, 16'h000F, 1, 1, 4, 1, 1, 6);
    applyStimulus();
    checkOutput("idle clears match", matchReg, 0);

    for (int i = 8; i < 30; i += 2) begin
      we_      = 2'b00;
      wd       = {16'h0C00 | 16'(i + 1), 16'h0C00 | 16'(i)};
      #1;
      pairAddr = {5'(i + 1), 5'(i)};
      checkOutput("fill wack", wackReg, 32'd3);
      checkOutput("fill waddr", waddrReg, pairAddr);
      applyStimulus();
    end
    we_ = 2'b11;
    allocOne(16'h0C1E, 16'h0000, 30);
    checkOutput("count 31", countReg, 31);

    we_ = 2'b00;
    #1;
    checkOutput("last slot wack", wackReg, 32'd1);
    checkOutput("last slot waddr", waddrReg, 31);
    applyStimulus();
    we_ = 2'b11;
    checkOutput("count full", countReg, 32);
    checkOutput("full flag", fullReg, 1);

    inv_  = 2'b00;
    iaddr = {5'd5, 5'd5};
    we_   = 2'b10;
    #1;
    checkOutput("wack while full", wackReg, 0);
    applyStimulus();
    idleInputs();
    checkOutput("count after inv", countReg, 31);
    checkOutput("full after inv", fullReg, 0);
    allocOne(16'hBEEF, 16'h0000, 5);
    checkOutput("count refilled", countReg, 32);
    searchPort(0, 16'hBEEF, 16'h0000, 1, 0, 5, 1, 0, 5);

    flush_ = 1'b0;
    we_    = 2'b00;
    #1;
    checkOutput("flush wack", wackReg, 0);
    checkOutput("flush wack comb", wackComb, 0);
    applyStimulus();
    idleInputs();
    checkOutput("count after flush", countReg, 0);
    checkOutput("empty after flush", emptyReg, 1);
    searchPort(1, 16'h0000, 16'hFFFF, 0, 0, 0, 0, 0, 0);

    inv_  = 2'b10;
    iaddr = {5'd0, 5'd3};
    applyStimulus();
    idleInputs();
    checkOutput("inv of invalid", countReg, 0);

    allocOne(16'h1234, 16'h0000, 0);
    re_     = 2'b10;
    rd[15:0] = 16'h1234;
    rm[15:0] = 16'h0000;
    applyStimulus();
    checkOutput("pre-reset match", matchReg, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset match", matchReg, 0);
    checkOutput("async reset count", countReg, 0);
    checkOutput("async reset empty", emptyReg, 1);
    idleInputs();
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
